// File: rtl/voice_match_engine.sv
// Voice match engine: records one utterance into an external capture RAM, then
// streams it back against N_DIRS template channels, tallying per-lane matches
// and reporting the channel with the uniquely highest tally.
module voice_match_engine #(
  parameter int N_DIRS      = 4,
  parameter int SAMPLE_W    = 8,
  parameter int CHUNKS      = 2830,
  parameter int ADDR_W      = 12,
  parameter int THRESH      = 3,
  parameter int CNT_W       = 14,
  parameter int DEFAULT_DIR = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           compare_en,
  input  logic                           abort,
  input  logic                           sample_valid,
  input  logic [4*SAMPLE_W-1:0]          sample_data,
  output logic                           ram_wr,
  output logic [4*SAMPLE_W-1:0]          ram_wdata,
  output logic [ADDR_W-1:0]              ram_addr,
  input  logic [4*SAMPLE_W-1:0]          ram_rdata,
  input  logic [N_DIRS*4*SAMPLE_W-1:0]   tmpl_rdata,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N_DIRS)-1:0]      match,
  output logic                           match_valid
);

  localparam int LW = 4 * SAMPLE_W;
  localparam int MW = $clog2(N_DIRS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNKS - 1);
  localparam logic [MW-1:0] DEF_DIR = MW'(DEFAULT_DIR);
  localparam logic signed [SAMPLE_W:0] THR = (SAMPLE_W + 1)'(THRESH);

  typedef enum logic [2:0] {IDLE, RECORD, COMPARE, DRAIN, RESULT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic               cen_q;
  logic               rd_vld_p0;
  logic [CNT_W-1:0]   tally [N_DIRS];
  logic [2:0]         score [N_DIRS];
  logic [MW-1:0]      best_idx;
  logic [CNT_W-1:0]   best_val;
  logic               tie;

  // Number of lanes (0..4) whose unsigned absolute difference is within THRESH.
  function automatic logic [2:0] word_score(input logic [LW-1:0] a,
                                            input logic [LW-1:0] b);
    logic signed [SAMPLE_W:0] diff;
    logic [2:0] sc;
    sc = '0;
    for (int l = 0; l < 4; l++) begin
      diff = $signed({1'b0, a[l*SAMPLE_W +: SAMPLE_W]}) -
             $signed({1'b0, b[l*SAMPLE_W +: SAMPLE_W]});
      if (diff < 0) diff = -diff;
      if (diff <= THR) sc = sc + 3'd1;
    end
    return sc;
  endfunction

  // Saturating tally update: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] t,
                                               input logic [2:0] s);
    logic [CNT_W:0] sum;
    sum = {1'b0, t} + {{(CNT_W-2){1'b0}}, s};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign busy      = (state != IDLE);
  assign ram_wr    = (state == RECORD) && sample_valid && !abort;
  assign ram_wdata = sample_data;
  assign ram_addr  = addr;

  // Per-channel score of the read word currently on the RAM data buses.
  always_comb begin
    for (int i = 0; i < N_DIRS; i++)
      score[i] = word_score(ram_rdata, tmpl_rdata[i*LW +: LW]);
  end

  // Winner search: tie is set whenever the running maximum is matched.
  always_comb begin
    best_idx = '0;
    best_val = tally[0];
    tie      = 1'b0;
    for (int i = 1; i < N_DIRS; i++) begin
      if (tally[i] > best_val) begin
        best_idx = MW'(i);
        best_val = tally[i];
        tie      = 1'b0;
      end else if (tally[i] == best_val) begin
        tie = 1'b1;
      end
    end
  end

  // Control FSM with registered done/match outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cen_q       <= 1'b0;
      rd_vld_p0   <= 1'b0;
      done        <= 1'b0;
      match       <= DEF_DIR;
      match_valid <= 1'b0;
    end else begin
      done      <= 1'b0;
      rd_vld_p0 <= 1'b0;
      if (abort) begin
        state <= IDLE;
        addr  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              addr  <= '0;
              cen_q <= compare_en;
              state <= RECORD;
            end
          end
          RECORD: begin
            if (sample_valid) begin
              if (addr == LAST_ADDR) begin
                addr <= '0;
                if (cen_q) begin
                  state <= COMPARE;
                end else begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              end else begin
                addr <= addr + 1'b1;
              end
            end
          end
          COMPARE: begin
            // stage p0: address issued now, read data arrives next cycle
            rd_vld_p0 <= 1'b1;
            if (addr == LAST_ADDR) begin
              addr  <= '0;
              state <= DRAIN;
            end else begin
              addr <= addr + 1'b1;
            end
          end
          DRAIN: begin
            state <= RESULT;
          end
          RESULT: begin
            match       <= tie ? DEF_DIR : best_idx;
            match_valid <= !tie;
            done        <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tallies: cleared on a new capture, accumulated one cycle after each read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIRS; i++) tally[i] <= '0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        for (int i = 0; i < N_DIRS; i++) tally[i] <= '0;
      end else if (rd_vld_p0) begin
        for (int i = 0; i < N_DIRS; i++) tally[i] <= sat_add(tally[i], score[i]);
      end
    end
  end

endmodule
